// File: rtl/sram_lsu_ctrl_if.sv
// Bundles for sram_lsu_ctrl: LSU request/response handshake and SRAM port-0 (1RW) pins.
interface sram_lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    modport master (output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
                    input  req_ready, rsp_valid, rsp_err, rsp_rdata);
    modport slave  (input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
                    output req_ready, rsp_valid, rsp_err, rsp_rdata);
endinterface

interface sram_lsu_mem_if #(parameter int ADDR_WIDTH = 8);
    logic                  csb;
    logic                  web;
    logic [3:0]            wmask;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           din;
    logic [31:0]           dout;

    modport master (output csb, web, wmask, addr, din, input dout);
    modport slave  (input  csb, web, wmask, addr, din, output dout);
endinterface

// File: rtl/sram_lsu_ctrl.sv
// LSU-to-SRAM port-0 controller: byte masks, lane replication, load alignment and extension.
// Optional upper-address range check enabled by defining SRAM_LSU_RANGE_CHK_EN.
//   state   | meaning
//   IDLE    | ready for a request
//   ACCESS  | SRAM request driven, sampled by the macro on the next edge
//   CAPTURE | waiting for dout0, extended lane registered on exit
//   RESP    | rsp_valid high for one cycle
module sram_lsu_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    sram_lsu_req_if.slave  lsu,
    sram_lsu_mem_if.master sram
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    csb_q, csb_d;
    logic                    web_q, web_d;
    logic [3:0]              wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             din_q, din_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              lo_q, lo_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;

    logic                    accept, align_ok, range_ok;
    logic [3:0]              st_mask;
    logic [31:0]             st_data;
    logic [7:0]              lane_b;
    logic [15:0]             lane_h;
    logic [DATA_WIDTH-1:0]   ext;

    assign accept = lsu.req_valid & ready_q;

    always_comb begin
        align_ok = 1'b0;
        case (lsu.req_size)
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~lsu.req_addr[0];
            2'b10:   align_ok = (lsu.req_addr[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
    end

`ifdef SRAM_LSU_RANGE_CHK_EN
    assign range_ok = (lsu.req_addr[31:ADDR_WIDTH+2] == '0);
`else
    // Upper address bits are ignored; accesses wrap within the macro.
    logic unused_addr_hi;
    assign unused_addr_hi = ^lsu.req_addr[31:ADDR_WIDTH+2];
    assign range_ok = 1'b1;
`endif

    always_comb begin
        st_mask = 4'b1111;
        st_data = lsu.req_wdata;
        case (lsu.req_size)
            2'b00: begin
                st_mask = 4'b0001 << lsu.req_addr[1:0];
                st_data = {4{lsu.req_wdata[7:0]}};
            end
            2'b01: begin
                st_mask = lsu.req_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{lsu.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_b = sram.dout[7:0];
        case (lo_q)
            2'd1:    lane_b = sram.dout[15:8];
            2'd2:    lane_b = sram.dout[23:16];
            2'd3:    lane_b = sram.dout[31:24];
            default: ;
        endcase
        lane_h = lo_q[1] ? sram.dout[31:16] : sram.dout[15:0];
        case (size_q)
            2'b00:   ext = {{24{~uns_q & lane_b[7]}}, lane_b};
            2'b01:   ext = {{16{~uns_q & lane_h[15]}}, lane_h};
            default: ext = sram.dout;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b0;
        csb_d       = 1'b1;
        web_d       = 1'b1;
        wmask_d     = wmask_q;
        addr_d      = addr_q;
        din_d       = din_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rdata_d     = '0;
        lo_d        = lo_q;
        size_d      = size_q;
        uns_d       = uns_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    ready_d = 1'b0;
                    lo_d    = lsu.req_addr[1:0];
                    size_d  = lsu.req_size;
                    uns_d   = lsu.req_unsigned;
                    if (align_ok && range_ok) begin
                        state_d = ACCESS;
                        csb_d   = 1'b0;
                        web_d   = ~lsu.req_we;
                        addr_d  = lsu.req_addr[ADDR_WIDTH+1:2];
                        wmask_d = lsu.req_we ? st_mask : 4'b0000;
                        if (lsu.req_we) din_d = st_data;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // web_q still reflects the access being sampled this edge
                state_d     = web_q ? CAPTURE : RESP;
                rsp_valid_d = ~web_q;
            end
            CAPTURE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rdata_d     = ext;
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            wmask_q     <= 4'b0000;
            addr_q      <= '0;
            din_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
            lo_q        <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            wmask_q     <= wmask_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
            lo_q        <= lo_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
        end
    end

    assign lsu.req_ready  = ready_q;
    assign lsu.rsp_valid  = rsp_valid_q;
    assign lsu.rsp_err    = rsp_err_q;
    assign lsu.rsp_rdata  = rdata_q;
    assign sram.csb       = csb_q;
    assign sram.web       = web_q;
    assign sram.wmask     = wmask_q;
    assign sram.addr      = addr_q;
    assign sram.din       = din_q;
endmodule

// File: tb/tb_sram_lsu_ctrl.sv
// Directed bench for sram_lsu_ctrl with a behavioural 32x256 SRAM port-0 model.
module tb_sram_lsu_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_lsu_req_if lsu();
    sram_lsu_mem_if #(.ADDR_WIDTH(8)) mem();

    sram_lsu_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .lsu  (lsu),
        .sram (mem)
    );

    // SRAM model: samples at posedge, writes or drives dout at the following negedge.
    logic [31:0] ram [0:255];
    logic        loaded = 1'b0;
    logic        pend_q, pend_we_q;
    logic [7:0]  pend_a_q;
    logic [3:0]  pend_m_q;
    logic [31:0] pend_d_q;

    always @(posedge clk) begin
        pend_q    <= (mem.csb === 1'b0);
        pend_we_q <= (mem.web === 1'b0);
        pend_a_q  <= mem.addr;
        pend_m_q  <= mem.wmask;
        pend_d_q  <= mem.din;
    end

    always @(negedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
            ram[0]   <= 32'h11223344;
            ram[2]   <= 32'hfc010113;
            ram[128] <= 32'h01234567;
            loaded   <= 1'b1;
        end else if (pend_q) begin
            if (pend_we_q) begin
                for (int b = 0; b < 4; b++)
                    if (pend_m_q[b]) ram[pend_a_q][8*b +: 8] <= pend_d_q[8*b +: 8];
            end else begin
                mem.dout <= ram[pend_a_q];
            end
        end
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] rd, dn;
    logic        er;
    int          lt, cn, wn;
    logic [3:0]  wm;
    logic [7:0]  sa;

    task automatic transact(input string tag, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        logic got;
        got = 1'b0; lt = 0; cn = 0; wn = 0;
        rd = 'x; er = 1'bx; wm = 'x; dn = 'x; sa = 'x;
        @(negedge clk);
        chk({tag, ":ready_before"}, {31'b0, lsu.req_ready}, 32'd1);
        lsu.req_valid    = 1'b1;
        lsu.req_we       = we;
        lsu.req_size     = size;
        lsu.req_unsigned = uns;
        lsu.req_addr     = addr;
        lsu.req_wdata    = wdata;
        @(posedge clk);
        #1 lsu.req_valid = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (mem.csb === 1'b0) begin
                cn++;
                wm = mem.wmask; dn = mem.din; sa = mem.addr;
            end
            if (mem.web === 1'b0) wn++;
            if (lsu.rsp_valid === 1'b1) begin
                got = 1'b1; lt = k; rd = lsu.rsp_rdata; er = lsu.rsp_err;
            end else begin
                @(posedge clk);
            end
        end
        chk({tag, ":rsp_seen"}, {31'b0, got}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ":rsp_one_cycle"}, {31'b0, lsu.rsp_valid}, 32'd0);
        chk({tag, ":ready_back"}, {31'b0, lsu.req_ready}, 32'd1);
    endtask

    task automatic load_chk(input string tag, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] exp);
        transact(tag, 1'b0, size, uns, addr, 32'h0);
        chk({tag, ":rdata"}, rd, exp);
        chk({tag, ":err"}, {31'b0, er}, 32'd0);
        chk({tag, ":latency"}, 32'(lt), 32'd3);
        chk({tag, ":csb_cycles"}, 32'(cn), 32'd1);
        chk({tag, ":sram_addr"}, {24'b0, sa}, {24'b0, addr[9:2]});
    endtask

    task automatic store_chk(input string tag, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] exp_m,
                             input logic [31:0] exp_d);
        transact(tag, 1'b1, size, 1'b0, addr, wdata);
        chk({tag, ":wmask"}, {28'b0, wm}, {28'b0, exp_m});
        chk({tag, ":din"}, dn, exp_d);
        chk({tag, ":web_cycles"}, 32'(wn), 32'd1);
        chk({tag, ":csb_cycles"}, 32'(cn), 32'd1);
        chk({tag, ":latency"}, 32'(lt), 32'd2);
        chk({tag, ":err"}, {31'b0, er}, 32'd0);
        chk({tag, ":rdata"}, rd, 32'd0);
    endtask

    task automatic err_chk(input string tag, input logic we, input logic [1:0] size,
                           input logic [31:0] addr);
        transact(tag, we, size, 1'b0, addr, 32'hdeadbeef);
        chk({tag, ":err"}, {31'b0, er}, 32'd1);
        chk({tag, ":rdata"}, rd, 32'd0);
        chk({tag, ":latency"}, 32'(lt), 32'd1);
        chk({tag, ":csb_cycles"}, 32'(cn), 32'd0);
        chk({tag, ":web_cycles"}, 32'(wn), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int vcount;
        rst = 1'b1;
        lsu.req_valid = 1'b0; lsu.req_we = 1'b0; lsu.req_size = 2'b00;
        lsu.req_unsigned = 1'b0; lsu.req_addr = 32'h0; lsu.req_wdata = 32'h0;
        #2;
        chk("rst:csb", {31'b0, mem.csb}, 32'd1);
        chk("rst:web", {31'b0, mem.web}, 32'd1);
        chk("rst:wmask", {28'b0, mem.wmask}, 32'd0);
        chk("rst:addr", {24'b0, mem.addr}, 32'd0);
        chk("rst:din", mem.din, 32'd0);
        chk("rst:ready", {31'b0, lsu.req_ready}, 32'd0);
        chk("rst:rsp_valid", {31'b0, lsu.rsp_valid}, 32'd0);
        chk("rst:rsp_err", {31'b0, lsu.rsp_err}, 32'd0);
        chk("rst:rdata", lsu.rsp_rdata, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("rst:ready_after", {31'b0, lsu.req_ready}, 32'd1);

        load_chk("lw_008",  2'b10, 1'b0, 32'h008, 32'hfc010113);
        load_chk("lbs_00b", 2'b00, 1'b0, 32'h00b, 32'hfffffffc);
        load_chk("lhu_00a", 2'b01, 1'b1, 32'h00a, 32'h0000fc01);
        load_chk("lhs_00a", 2'b01, 1'b0, 32'h00a, 32'hfffffc01);
        load_chk("lbu_00b", 2'b00, 1'b1, 32'h00b, 32'h000000fc);
        load_chk("lbs_009", 2'b00, 1'b0, 32'h009, 32'h00000001);
        load_chk("lhs_008", 2'b01, 1'b0, 32'h008, 32'h00000113);
        load_chk("lbs_008", 2'b00, 1'b0, 32'h008, 32'h00000013);

        store_chk("sb_201", 2'b00, 32'h201, 32'h000000a5, 4'b0010, 32'ha5a5a5a5);
        chk("sb_201:sram_addr", {24'b0, sa}, 32'h80);
        load_chk("lw_200a", 2'b10, 1'b0, 32'h200, 32'h0123a567);
        store_chk("sh_202", 2'b01, 32'h202, 32'h1234beef, 4'b1100, 32'hbeefbeef);
        load_chk("lw_200b", 2'b10, 1'b0, 32'h200, 32'hbeefa567);
        store_chk("sw_00c", 2'b10, 32'h00c, 32'hcafef00d, 4'b1111, 32'hcafef00d);
        load_chk("lbs_00f", 2'b00, 1'b0, 32'h00f, 32'hffffffca);
        load_chk("lhu_00c", 2'b01, 1'b1, 32'h00c, 32'h0000f00d);

        err_chk("lw_006_misal", 1'b0, 2'b10, 32'h006);
        err_chk("size11",       1'b0, 2'b11, 32'h008);
        err_chk("lh_001_misal", 1'b0, 2'b01, 32'h001);
        err_chk("sw_002_misal", 1'b1, 2'b10, 32'h002);
        load_chk("lw_008_again", 2'b10, 1'b0, 32'h008, 32'hfc010113);

`ifdef SRAM_LSU_RANGE_CHK_EN
        err_chk("lw_400_range", 1'b0, 2'b10, 32'h400);
`else
        load_chk("lw_400_wrap", 2'b10, 1'b0, 32'h400, 32'h11223344);
`endif

        // Reset while the access is being driven
        @(negedge clk);
        lsu.req_valid = 1'b1; lsu.req_we = 1'b0; lsu.req_size = 2'b10; lsu.req_addr = 32'h008;
        @(posedge clk);
        #1 lsu.req_valid = 1'b0;
        chk("rst_access:csb_low", {31'b0, mem.csb}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_access:csb", {31'b0, mem.csb}, 32'd1);
        chk("rst_access:ready", {31'b0, lsu.req_ready}, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("rst_access:ready_after", {31'b0, lsu.req_ready}, 32'd1);

        // Reset during CAPTURE of a load
        @(negedge clk);
        lsu.req_valid = 1'b1; lsu.req_we = 1'b0; lsu.req_size = 2'b10; lsu.req_addr = 32'h008;
        @(posedge clk);
        #1 lsu.req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_capture:csb", {31'b0, mem.csb}, 32'd1);
        chk("rst_capture:rsp_valid", {31'b0, lsu.rsp_valid}, 32'd0);
        chk("rst_capture:rdata", lsu.rsp_rdata, 32'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        vcount = 0;
        @(negedge clk);
        chk("rst_capture:ready_after", {31'b0, lsu.req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (lsu.rsp_valid === 1'b1) vcount++;
            @(negedge clk);
        end
        chk("rst_capture:no_rsp", 32'(vcount), 32'd0);

        load_chk("lw_after_rst", 2'b10, 1'b0, 32'h008, 32'hfc010113);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
